// File: rtl/wire_event_capture.sv
// wire_event_capture: synchronizes an asynchronous wire bus, timestamps every
// change with a free-running counter and queues event records in a
// first-word-fall-through FIFO read out over a valid/ready handshake.
// Records that arrive while the FIFO is full are dropped. Each drop sets a
// sticky overflow flag and increments a saturating drop counter.
module wire_event_capture #(
    parameter int WIRE_W     = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [WIRE_W-1:0]             d_bus,
    input  logic                          clr_ovf,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [1:0]                    ev_kind,
    output logic [WIRE_W-1:0]             ev_data,
    output logic [TS_W-1:0]               ev_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = 2 + WIRE_W + TS_W;

    localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]  KIND_SNAP   = 2'd0;
    localparam logic [1:0]  KIND_CHANGE = 2'd1;
    localparam logic [1:0]  KIND_WRAP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [WIRE_W-1:0]   s1_q, s2_q;
    logic [WIRE_W-1:0]   prev_q, prev_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic                wrap_pend_q, wrap_pend_d;

    logic                push_req;
    logic [1:0]          push_kind;
    logic [WIRE_W-1:0]   push_data;
    logic [TS_W-1:0]     push_ts;

    logic [REC_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [7:0]          drop_base;

    logic                fifo_empty, fifo_full;
    logic                pop, push_ok, drop;
    logic [REC_W-1:0]    head_rec;

    // Two-flop synchronizer bringing the raw wires into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_bus;
            s2_q <= s1_q;
        end
    end

    // Capture state register together with the datapath it governs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            ts_q        <= '0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            ts_q        <= ts_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    // Next-state logic: every arming passes through a one-cycle snapshot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable ? SNAP : IDLE;
            SNAP:    state_d = RUN;
            RUN:     state_d = enable ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Record generation: the snapshot, then changes, which take priority over a pending wrap marker.
    always_comb begin
        push_req    = 1'b0;
        push_kind   = KIND_SNAP;
        push_data   = s2_q;
        push_ts     = '0;
        prev_d      = prev_q;
        ts_d        = ts_q;
        wrap_pend_d = wrap_pend_q;
        case (state_q)
            IDLE: begin
                ts_d        = '0;
                wrap_pend_d = 1'b0;
            end
            SNAP: begin
                push_req    = 1'b1;
                push_kind   = KIND_SNAP;
                push_data   = s2_q;
                push_ts     = '0;
                prev_d      = s2_q;
                ts_d        = TS_W'(1);
                wrap_pend_d = 1'b0;
            end
            RUN: begin
                if (!enable) begin
                    ts_d        = '0;
                    wrap_pend_d = 1'b0;
                end else begin
                    ts_d = ts_q + TS_W'(1);
                    if (s2_q != prev_q) begin
                        push_req  = 1'b1;
                        push_kind = KIND_CHANGE;
                        push_data = s2_q;
                        push_ts   = ts_q;
                        prev_d    = s2_q;
                    end else if (wrap_pend_q) begin
                        push_req    = 1'b1;
                        push_kind   = KIND_WRAP;
                        push_data   = prev_q;
                        push_ts     = '0;
                        wrap_pend_d = 1'b0;
                    end
                    if (ts_q == '1) begin
                        wrap_pend_d = 1'b1;
                    end
                end
            end
            default: begin
                ts_d        = '0;
                wrap_pend_d = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping: a pop frees room for a push in the same cycle, so only a full FIFO with no pop drops.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_LEVEL);
        pop        = !fifo_empty && ev_ready;
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end

        overflow_d = clr_ovf ? 1'b0 : overflow_q;
        drop_base  = clr_ovf ? 8'd0 : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
        end
    end

    // FIFO pointers, level and overflow status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage, written only when the push is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_kind, push_data, push_ts};
        end
    end

    // Head record fields read straight out of storage (fall-through) and zeroed while empty.
    always_comb begin
        head_rec   = fifo_empty ? '0 : mem_q[rd_ptr_q];
        ev_valid   = !fifo_empty;
        ev_kind    = head_rec[REC_W-1 -: 2];
        ev_data    = head_rec[TS_W +: WIRE_W];
        ev_ts      = head_rec[TS_W-1:0];
        fifo_level = count_q;
        overflow   = overflow_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule

// File: tb/tb_wire_event_capture.sv
// tb_wire_event_capture: directed scenarios for wire_event_capture. A second
// instance with a 4-bit timestamp drives the counter to wrap within a few cycles.
module tb_wire_event_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [7:0]  d_bus;
    logic        clr_ovf;
    logic        ev_ready;

    logic        ev_valid;
    logic [1:0]  ev_kind;
    logic [7:0]  ev_data;
    logic [15:0] ev_ts;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic        w_valid;
    logic [1:0]  w_kind;
    logic [7:0]  w_data;
    logic [3:0]  w_ts;
    logic [3:0]  w_level;
    logic        w_overflow;
    logic [7:0]  w_drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wire_event_capture #(.WIRE_W(8), .TS_W(16), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .d_bus      (d_bus),
        .clr_ovf    (clr_ovf),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_kind    (ev_kind),
        .ev_data    (ev_data),
        .ev_ts      (ev_ts),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    wire_event_capture #(.WIRE_W(8), .TS_W(4), .FIFO_DEPTH(8)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .d_bus      (d_bus),
        .clr_ovf    (clr_ovf),
        .ev_valid   (w_valid),
        .ev_ready   (ev_ready),
        .ev_kind    (w_kind),
        .ev_data    (w_data),
        .ev_ts      (w_ts),
        .fifo_level (w_level),
        .overflow   (w_overflow),
        .drop_cnt   (w_drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // Raise enable; cyc 0 is the edge that enters the snapshot state, and after edge n the timestamp reads n.
    task automatic arm();
        enable = 1'b1;
        tick();
        cyc = 0;
    endtask

    task automatic start_run(input logic [7:0] val, input logic rdy);
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        enable   = 1'b0;
        clr_ovf  = 1'b0;
        ev_ready = rdy;
        d_bus    = val;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
        arm();
    endtask

    task automatic test_reset();
        logic [44:0] got;
        rstn = 1'b0; enable = 1'b0; clr_ovf = 1'b0; ev_ready = 1'b0; d_bus = 8'h00;
        #12;
        got = {ev_valid, ev_kind, ev_data, ev_ts, fifo_level, overflow, drop_cnt, w_valid, w_level};
        checks++;
        if (got !== 45'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0", got);
        end
    endtask

    task automatic test_snapshot();
        logic [26:0] got;
        start_run(8'hA5, 1'b0);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL snap_latency: ev_valid %b expected 0 at SNAP edge", ev_valid);
        end
        tick();
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd0, 8'hA5, 16'd0} || fifo_level !== 4'd1) begin
            errors++;
            $display("[TB] FAIL snap_record: got %h level %0d expected %h level 1", got, fifo_level, {1'b1, 2'd0, 8'hA5, 16'd0});
        end
        repeat (50) tick();
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("[TB] FAIL snap_quiet: level %0d expected 1", fifo_level);
        end
    endtask

    task automatic test_change_detect();
        logic [26:0] got;
        start_run(8'h00, 1'b1);
        tick_to(10);
        d_bus = 8'h01;
        tick_to(12);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL change_early: ev_valid %b expected 0", ev_valid);
        end
        tick_to(13);
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd1, 8'h01, 16'd12}) begin
            errors++;
            $display("[TB] FAIL change_01: got %h expected %h", got, {1'b1, 2'd1, 8'h01, 16'd12});
        end
        tick_to(20);
        d_bus = 8'h03;
        tick_to(23);
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd1, 8'h03, 16'd22}) begin
            errors++;
            $display("[TB] FAIL change_03: got %h expected %h", got, {1'b1, 2'd1, 8'h03, 16'd22});
        end
    endtask

    task automatic test_overflow();
        logic [26:0] got;
        logic [26:0] exp;
        start_run(8'h00, 1'b1);
        tick_to(2);
        ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_to(4 + 2 * i);
            if (i == 9) begin
                checks++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_full: level %0d ovf %b expected 8 0", fifo_level, overflow);
                end
            end
            d_bus = 8'(i + 1);
        end
        tick_to(26);
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL ovf_status: level %0d ovf %b drops %0d expected 8 1 2", fifo_level, overflow, drop_cnt);
        end
        ev_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            got = {ev_valid, ev_kind, ev_data, ev_ts};
            exp = {1'b1, 2'd1, 8'(j + 1), 16'(6 + 2 * j)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL ovf_drain%0d: got %h expected %h", j, got, exp);
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_empty: valid %b level %0d ovf %b expected 0 0 1", ev_valid, fifo_level, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: ovf %b drops %0d expected 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] got;
        start_run(8'h5A, 1'b1);
        tick_to(16);
        checks++;
        if (w_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_early: valid %b expected 0", w_valid);
        end
        tick_to(17);
        got = {w_valid, w_kind, w_data, w_ts};
        checks++;
        if (got !== {1'b1, 2'd2, 8'h5A, 4'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_marker1: got %h expected %h", got, {1'b1, 2'd2, 8'h5A, 4'd0});
        end
        tick_to(33);
        got = {w_valid, w_kind, w_data, w_ts};
        checks++;
        if (got !== {1'b1, 2'd2, 8'h5A, 4'd0} || w_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_marker2: got %h ovf %b expected %h ovf 0", got, w_overflow, {1'b1, 2'd2, 8'h5A, 4'd0});
        end
        tick_to(45);
        d_bus = 8'hC3;
        tick_to(48);
        got = {w_valid, w_kind, w_data, w_ts};
        checks++;
        if (got !== {1'b1, 2'd1, 8'hC3, 4'd15}) begin
            errors++;
            $display("[TB] FAIL wrap_change_first: got %h expected %h", got, {1'b1, 2'd1, 8'hC3, 4'd15});
        end
        tick_to(49);
        got = {w_valid, w_kind, w_data, w_ts};
        checks++;
        if (got !== {1'b1, 2'd2, 8'hC3, 4'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_marker_after: got %h expected %h", got, {1'b1, 2'd2, 8'hC3, 4'd0});
        end
        tick_to(50);
        checks++;
        if (w_valid !== 1'b0 || w_level !== 4'd0) begin
            errors++;
            $display("[TB] FAIL wrap_single: valid %b level %0d expected 0 0", w_valid, w_level);
        end
    endtask

    task automatic test_full_with_pop();
        logic [26:0] got;
        logic [26:0] exp;
        start_run(8'h00, 1'b1);
        tick_to(2);
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick_to(4 + 2 * i);
            d_bus = 8'(i + 1);
        end
        tick_to(22);
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++;
            $display("[TB] FAIL full_level: level %0d expected 8", fifo_level);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0 || got !== {1'b1, 2'd1, 8'h02, 16'd8}) begin
            errors++;
            $display("[TB] FAIL full_pushpop: level %0d ovf %b drops %0d head %h expected 8 0 0 %h", fifo_level, overflow, drop_cnt, got, {1'b1, 2'd1, 8'h02, 16'd8});
        end
        ev_ready = 1'b1;
        for (int j = 1; j < 9; j++) begin
            got = {ev_valid, ev_kind, ev_data, ev_ts};
            exp = {1'b1, 2'd1, 8'(j + 1), 16'(6 + 2 * j)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL full_order%0d: got %h expected %h", j, got, exp);
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_empty: valid %b expected 0", ev_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [26:0] got;
        start_run(8'h00, 1'b0);
        tick_to(4); d_bus = 8'h01;
        tick_to(6); d_bus = 8'h02;
        tick_to(8); d_bus = 8'h03;
        tick_to(12);
        checks++;
        if (fifo_level !== 4'd4) begin
            errors++;
            $display("[TB] FAIL rst_queued: level %0d expected 4", fifo_level);
        end
        #2;
        rstn = 1'b0;
        #1;
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== 27'd0 || fifo_level !== 4'd0) begin
            errors++;
            $display("[TB] FAIL rst_async: got %h level %0d expected 0 0", got, fifo_level);
        end
        start_run(8'h77, 1'b0);
        tick();
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd0, 8'h77, 16'd0} || fifo_level !== 4'd1) begin
            errors++;
            $display("[TB] FAIL rst_fresh_snap: got %h level %0d expected %h 1", got, fifo_level, {1'b1, 2'd0, 8'h77, 16'd0});
        end
    endtask

    task automatic test_enable_toggle();
        logic [26:0] got;
        start_run(8'h00, 1'b0);
        tick_to(4);
        d_bus = 8'h11;
        tick_to(8);
        enable = 1'b0;
        tick_to(14);
        d_bus = 8'h22;
        tick_to(18);
        checks++;
        if (fifo_level !== 4'd2) begin
            errors++;
            $display("[TB] FAIL idle_level: level %0d expected 2", fifo_level);
        end
        ev_ready = 1'b1;
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd0, 8'h00, 16'd0}) begin
            errors++;
            $display("[TB] FAIL idle_drain0: got %h expected %h", got, {1'b1, 2'd0, 8'h00, 16'd0});
        end
        tick();
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd1, 8'h11, 16'd6}) begin
            errors++;
            $display("[TB] FAIL idle_drain1: got %h expected %h", got, {1'b1, 2'd1, 8'h11, 16'd6});
        end
        tick();
        ev_ready = 1'b0;
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_empty: valid %b expected 0", ev_valid);
        end
        arm();
        tick();
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd0, 8'h22, 16'd0}) begin
            errors++;
            $display("[TB] FAIL rearm_snap: got %h expected %h", got, {1'b1, 2'd0, 8'h22, 16'd0});
        end
        tick_to(3);
        d_bus = 8'h33;
        tick_to(6);
        ev_ready = 1'b1;
        tick();
        got = {ev_valid, ev_kind, ev_data, ev_ts};
        checks++;
        if (got !== {1'b1, 2'd1, 8'h33, 16'd5}) begin
            errors++;
            $display("[TB] FAIL rearm_ts: got %h expected %h", got, {1'b1, 2'd1, 8'h33, 16'd5});
        end
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_snapshot();
        test_change_detect();
        test_overflow();
        test_wrap();
        test_full_with_pop();
        test_reset_mid_run();
        test_enable_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
